instr_encoder: RTL and testbench

Sequential MIPS instruction encoder, the inverse of the main decoder's opcode path. It takes field-level instruction requests (class, registers, immediate/target) over a valid/ready handshake and emits 32-bit instruction words, each tagged with a sequential instruction-memory word address. Used by the program loader and the testbench to fill imem, so every word it emits must decode back to the same control word.

---
 rtl/instr_encoder_if.sv | 33 +++
 rtl/instr_encoder.sv | 80 ++++++++
 tb/tb_instr_encoder.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Request/response bus between an instruction-field producer and the encoder.
interface instr_encoder_if #(
   parameter int ADDR_W = 6
);
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_class;
   logic [4:0]        in_rs;
   logic [4:0]        in_rt;
   logic [4:0]        in_rd;
   logic [4:0]        in_shamt;
   logic [5:0]        in_funct;
   logic [15:0]       in_imm;
   logic [25:0]       in_target;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_instr;
   logic [ADDR_W-1:0] out_addr;

   // Requester side: drives fields, consumes encoded words.
   modport master (
      output in_valid, in_class, in_rs, in_rt, in_rd, in_shamt, in_funct,
             in_imm, in_target, out_ready,
      input  in_ready, out_valid, out_instr, out_addr
   );

   // Encoder side.
   modport slave (
      input  in_valid, in_class, in_rs, in_rt, in_rd, in_shamt, in_funct,
             in_imm, in_target, out_ready,
      output in_ready, out_valid, out_instr, out_addr
   );
endinterface

// File: rtl/instr_encoder.sv
// Field-level MIPS instruction encoder with a single-entry output register.
// Each legal word is tagged with a sequential imem word address.
module instr_encoder #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   instr_encoder_if.slave    bus,
   output logic              err,
   output logic [2:0]        err_class,
   output logic              wrapped
);

   logic [ADDR_W-1:0] wptr;
   logic [31:0]       word;
   logic              legal;
   logic              accept;

   // Output stage can take a new word when empty or being drained this cycle.
   always_comb begin
      bus.in_ready = !clr && (!bus.out_valid || bus.out_ready);
      accept       = bus.in_valid && bus.in_ready;
   end

   // Opcode/field packing per instruction class; classes 6-7 are illegal.
   always_comb begin
      word  = 32'h0;
      legal = 1'b1;
      case (bus.in_class)
         3'd0:    word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd,
                          bus.in_shamt, bus.in_funct};
         3'd1:    word = {6'b100011, bus.in_rs, bus.in_rt, bus.in_imm};
         3'd2:    word = {6'b101011, bus.in_rs, bus.in_rt, bus.in_imm};
         3'd3:    word = {6'b000100, bus.in_rs, bus.in_rt, bus.in_imm};
         3'd4:    word = {6'b001000, bus.in_rs, bus.in_rt, bus.in_imm};
         3'd5:    word = {6'b000010, bus.in_target};
         default: legal = 1'b0;
      endcase
   end

   // Output register, write pointer and sticky flags; clr outranks everything.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.out_valid <= 1'b0;
         bus.out_instr <= 32'h0;
         bus.out_addr  <= '0;
         wptr          <= '0;
         err           <= 1'b0;
         err_class     <= 3'd0;
         wrapped       <= 1'b0;
      end else if (clr) begin
         bus.out_valid <= 1'b0;
         bus.out_instr <= 32'h0;
         bus.out_addr  <= '0;
         wptr          <= '0;
         err           <= 1'b0;
         err_class     <= 3'd0;
         wrapped       <= 1'b0;
      end else begin
         if (accept && legal) begin
            bus.out_valid <= 1'b1;
            bus.out_instr <= word;
            bus.out_addr  <= wptr;
            wptr          <= wptr + 1'b1;
            if (wptr == {ADDR_W{1'b1}})
               wrapped <= 1'b1;
         end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end
         // Illegal requests complete the handshake but only touch the flags.
         if (accept && !legal) begin
            err <= 1'b1;
            if (!err)
               err_class <= bus.in_class;
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder using a 2-bit address space.
module tb_instr_encoder;
   localparam int AW = 2;

   logic          clk;
   logic          reset;
   logic          clr;
   logic          err;
   logic [2:0]    err_class;
   logic          wrapped;
   int            n_checks;
   int            n_pass;

   instr_encoder_if #(.ADDR_W(AW)) bus ();

   instr_encoder #(.ADDR_W(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .clr       (clr),
      .bus       (bus),
      .err       (err),
      .err_class (err_class),
      .wrapped   (wrapped)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [2:0] cls, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd,
                          input logic [4:0] sh, input logic [5:0] fn,
                          input logic [15:0] imm, input logic [25:0] tgt);
      bus.in_valid  = 1'b1;
      bus.in_class  = cls;
      bus.in_rs     = rs;
      bus.in_rt     = rt;
      bus.in_rd     = rd;
      bus.in_shamt  = sh;
      bus.in_funct  = fn;
      bus.in_imm    = imm;
      bus.in_target = tgt;
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
   endtask

   task automatic pulse_clr();
      idle();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      reset    = 1'b1;
      clr      = 1'b0;
      bus.out_ready = 1'b1;
      idle();
      set_req(3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0);
      bus.in_valid = 1'b0;
      #12;
      check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check_val("rst_out_instr", bus.out_instr, 32'h0);
      check_val("rst_out_addr", 32'(bus.out_addr), 32'd0);
      check_val("rst_err", 32'(err), 32'd0);
      check_val("rst_err_class", 32'(err_class), 32'd0);
      check_val("rst_wrapped", 32'(wrapped), 32'd0);
      reset = 1'b0;
      tick();

      // ADDI then a second request picks up the next address
      set_req(3'd4, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0005, 26'h0);
      check_val("addi_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      check_val("addi_valid", 32'(bus.out_valid), 32'd1);
      check_val("addi_instr", bus.out_instr, 32'h20080005);
      check_val("addi_addr", 32'(bus.out_addr), 32'd0);
      set_req(3'd4, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0001, 26'h0);
      tick();
      check_val("addi2_instr", bus.out_instr, 32'h20210001);
      check_val("addi2_addr", 32'(bus.out_addr), 32'd1);
      idle();
      tick();
      check_val("drain_valid", 32'(bus.out_valid), 32'd0);
      pulse_clr();

      // Back-to-back LW / SW / BEQ
      set_req(3'd1, 5'd0, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0050, 26'h0);
      tick();
      check_val("lw_instr", bus.out_instr, 32'h8C020050);
      check_val("lw_addr", 32'(bus.out_addr), 32'd0);
      check_val("lw_in_ready", 32'(bus.in_ready), 32'd1);
      set_req(3'd2, 5'd0, 5'd7, 5'd0, 5'd0, 6'd0, 16'h0054, 26'h0);
      tick();
      check_val("sw_instr", bus.out_instr, 32'hAC070054);
      check_val("sw_addr", 32'(bus.out_addr), 32'd1);
      check_val("sw_valid", 32'(bus.out_valid), 32'd1);
      check_val("sw_in_ready", 32'(bus.in_ready), 32'd1);
      set_req(3'd3, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'h000A, 26'h0);
      tick();
      check_val("beq_instr", bus.out_instr, 32'h1085000A);
      check_val("beq_addr", 32'(bus.out_addr), 32'd2);
      check_val("beq_valid", 32'(bus.out_valid), 32'd1);
      idle();
      tick();
      pulse_clr();

      // RTYPE held under a 3-cycle stall, then J accepted on release
      bus.out_ready = 1'b0;
      set_req(3'd0, 5'd2, 5'd3, 5'd4, 5'd0, 6'h20, 16'hFFFF, 26'h3FFFFFF);
      tick();
      set_req(3'd5, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h0000011);
      for (int i = 0; i < 3; i++) begin
         check_val("stall_instr", bus.out_instr, 32'h00432020);
         check_val("stall_addr", 32'(bus.out_addr), 32'd0);
         check_val("stall_valid", 32'(bus.out_valid), 32'd1);
         check_val("stall_in_ready", 32'(bus.in_ready), 32'd0);
         tick();
      end
      bus.out_ready = 1'b1;
      #1;
      check_val("release_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      check_val("j_instr", bus.out_instr, 32'h08000011);
      check_val("j_addr", 32'(bus.out_addr), 32'd1);
      idle();
      tick();
      check_val("j_drain_valid", 32'(bus.out_valid), 32'd0);

      // Illegal classes: dropped, first class captured, pointer untouched
      set_req(3'd6, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'h1, 26'h1);
      check_val("ill6_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      check_val("ill6_valid", 32'(bus.out_valid), 32'd0);
      check_val("ill6_err", 32'(err), 32'd1);
      check_val("ill6_err_class", 32'(err_class), 32'd6);
      set_req(3'd7, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'h1, 26'h1);
      tick();
      check_val("ill7_valid", 32'(bus.out_valid), 32'd0);
      check_val("ill7_err_class", 32'(err_class), 32'd6);
      set_req(3'd4, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0005, 26'h0);
      tick();
      check_val("post_ill_instr", bus.out_instr, 32'h20080005);
      check_val("post_ill_addr", 32'(bus.out_addr), 32'd2);
      check_val("post_ill_wrapped", 32'(wrapped), 32'd0);
      check_val("post_ill_err", 32'(err), 32'd1);
      idle();
      tick();
      pulse_clr();

      // Pointer wrap with a 2-bit address
      for (int i = 0; i < 5; i++) begin
         set_req(3'd4, 5'd0, 5'(i), 5'd0, 5'd0, 6'd0, 16'(i), 26'h0);
         tick();
         check_val("wrap_addr", 32'(bus.out_addr), 32'(i % 4));
         check_val("wrap_instr", bus.out_instr,
                   32'h20000000 | (32'(i) << 16) | 32'(i));
         if (i == 2)
            check_val("wrap_early", 32'(wrapped), 32'd0);
      end
      check_val("wrap_flag", 32'(wrapped), 32'd1);
      idle();
      tick();

      // clr during a stall discards the pending word and blocks the request
      set_req(3'd7, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0);
      tick();
      check_val("pre_clr_err_class", 32'(err_class), 32'd7);
      bus.out_ready = 1'b0;
      set_req(3'd1, 5'd3, 5'd9, 5'd0, 5'd0, 6'd0, 16'h0010, 26'h0);
      tick();
      check_val("pre_clr_valid", 32'(bus.out_valid), 32'd1);
      check_val("pre_clr_instr", bus.out_instr, 32'h8C690010);
      set_req(3'd4, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0005, 26'h0);
      clr = 1'b1;
      #1;
      check_val("clr_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      clr = 1'b0;
      idle();
      check_val("clr_valid", 32'(bus.out_valid), 32'd0);
      check_val("clr_instr", bus.out_instr, 32'h0);
      check_val("clr_err", 32'(err), 32'd0);
      check_val("clr_err_class", 32'(err_class), 32'd0);
      check_val("clr_wrapped", 32'(wrapped), 32'd0);
      tick();
      check_val("clr_no_accept", 32'(bus.out_valid), 32'd0);

      // Asynchronous reset mid-cycle while a word is stalled
      set_req(3'd5, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0000ABC);
      tick();
      idle();
      check_val("pre_rst_instr", bus.out_instr, 32'h08000ABC);
      #2;
      reset = 1'b1;
      #1;
      check_val("async_rst_valid", 32'(bus.out_valid), 32'd0);
      check_val("async_rst_instr", bus.out_instr, 32'h0);
      reset = 1'b0;
      bus.out_ready = 1'b1;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
